// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target for 7-bit address + R/W followed by a 32-bit word, MSB first
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        tx_load,
  output logic        tx_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   sda_oe;
  logic [2:0]             bit_cnt;
  logic [1:0]             byte_cnt;
  logic                   got_byte;
  logic                   rw;
  logic [31:0]            shift_reg;

  logic        scl_s;
  logic        sda_s;
  logic        scl_rise;
  logic        scl_fall;
  logic        start_det;
  logic        stop_det;
  logic [31:0] rx_next;
  logic [7:0]  addr_byte;

  // Open-drain: the target only ever pulls low.
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
  assign rx_next   = {shift_reg[30:0], sda_s};
  assign addr_byte = rx_next[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // got_byte marks "8 bits seen, act on the next falling edge"; in TX_ACK it marks a received ACK.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      got_byte  <= 1'b0;
      rw        <= 1'b0;
      shift_reg <= 32'd0;
      sda_oe    <= 1'b0;
      rx_data   <= 32'd0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      tx_done  <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        byte_cnt  <= 2'd0;
        got_byte  <= 1'b0;
        shift_reg <= 32'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        got_byte <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift_reg <= rx_next;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_byte[7:1] == TARGET_ADDR) begin
                  got_byte <= 1'b1;
                  rw       <= addr_byte[0];
                end else begin
                  state <= IGNORE;
                end
              end
            end else if (scl_fall && got_byte) begin
              got_byte <= 1'b0;
              sda_oe   <= 1'b1;
              busy     <= 1'b1;
              state    <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (rw) begin
                shift_reg <= {tx_data[30:0], 1'b0};
                sda_oe    <= ~tx_data[31];
                tx_load   <= 1'b1;
                state     <= TX_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX_BYTE;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise) begin
              shift_reg <= rx_next;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                got_byte <= 1'b1;
                if (byte_cnt == 2'd3) begin
                  rx_data  <= rx_next;
                  rx_valid <= 1'b1;
                end
              end
            end else if (scl_fall && got_byte) begin
              got_byte <= 1'b0;
              sda_oe   <= 1'b1;
              state    <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              if (byte_cnt == 2'd3) begin
                state <= IGNORE;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                bit_cnt  <= 3'd0;
                state    <= RX_BYTE;
              end
            end
          end
          TX_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                got_byte <= 1'b1;
            end else if (scl_fall) begin
              if (got_byte) begin
                got_byte <= 1'b0;
                sda_oe   <= 1'b0;
                state    <= TX_ACK;
              end else begin
                sda_oe    <= ~shift_reg[31];
                shift_reg <= {shift_reg[30:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (byte_cnt == 2'd3) begin
                tx_done <= 1'b1;
                state   <= IGNORE;
              end else if (sda_s) begin
                state <= IGNORE;
              end else begin
                got_byte <= 1'b1;
              end
            end else if (scl_fall && got_byte) begin
              got_byte  <= 1'b0;
              byte_cnt  <= byte_cnt + 2'd1;
              bit_cnt   <= 3'd0;
              sda_oe    <= ~shift_reg[31];
              shift_reg <= {shift_reg[30:0], 1'b0};
              state     <= TX_BYTE;
            end
          end
          IDLE, IGNORE: begin
            sda_oe <= 1'b0;
          end
          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
